mem_read_port: RTL and testbench

- Memory-side controller that produces the Mdatain word consumed by the MDR and commits MDR contents to memory on writes.
- Accepts a MAR address plus read/write strobe from the control unit.
- Models a word-addressed RAM with fixed access latency.
- Returns read data plus a one-cycle done pulse that the control unit uses to assert MDRin/Read.

---
 rtl/mem_read_port_pkg.sv | 28 ++
 rtl/mem_read_port_mem_array.sv | 39 +++
 rtl/mem_read_port.sv | 166 ++++++++++++++++
 tb/tb_mem_read_port.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_read_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_read_port_pkg
//  Description : Shared types and constants for the memory read/write port.
//                Holds the controller FSM state encoding, the access-type
//                encoding and the default data width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_read_port_pkg;

  // Default word width, matches the MDR / bus width.
  localparam int c_data_w_default = 32;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Access type latched at request acceptance.
  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } op_t;

endpackage : mem_read_port_pkg
`default_nettype wire

// File: rtl/mem_read_port_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : Word-addressed RAM, DATA_W x 2**ADDR_W. Synchronous write,
//                combinational (asynchronous) read. Contents are never reset.
//  Ports       : clk   - system clock
//                we    - write enable, sampled on rising edge of clk
//                waddr - write address
//                wdata - write data
//                raddr - read address
//                rdata - read data (combinational from raddr)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int c_depth = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [0:c_depth-1];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : mem_array
`default_nettype wire

// File: rtl/mem_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : mem_read_port
//  Description : Memory-side controller for the MDR. Accepts a read or write
//                request (MAR address, MDR data) in IDLE, waits a fixed
//                LATENCY, then completes with a one-cycle mem_done pulse.
//                Read data is registered into mdatain on the edge entering
//                DONE; write data is committed to RAM on the edge leaving DONE.
//  Ports       : clk      - system clock, all state on rising edge
//                clr      - asynchronous active-high reset
//                mar_q    - address from MAR
//                mdr_q    - write data from MDR
//                read     - read strobe (level, sampled in IDLE)
//                write    - write strobe (level, sampled in IDLE, has priority)
//                mdatain  - registered read data to MDR
//                mem_done - one-cycle completion pulse
//                mem_busy - high while an access is in flight
//                mem_err  - (MEM_RANGE_CHECK_EN only) out-of-range access,
//                           pulses together with mem_done
//  Options     : `define MEM_RANGE_CHECK_EN adds parameter MEM_WORDS and the
//                mem_err output; addresses >= MEM_WORDS read as 0 and are
//                never written.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_read_port
  import mem_read_port_pkg::*;
#(
  parameter int DATA_W    = c_data_w_default,
  parameter int ADDR_W    = 9,
  parameter int LATENCY   = 2
`ifdef MEM_RANGE_CHECK_EN
  ,
  parameter int MEM_WORDS = 1 << ADDR_W
`endif
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] mar_q,
  input  logic [DATA_W-1:0] mdr_q,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] mdatain,
  output logic              mem_done,
`ifdef MEM_RANGE_CHECK_EN
  output logic              mem_err,
`endif
  output logic              mem_busy
);

  // Counter reload at acceptance; WAIT leaves when it reaches 1.
  localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  op_t               r_op;
  op_t               w_op_acc;
  op_t               w_rd_op;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] r_mdatain;
  logic              r_err;
  logic              w_addr_err;
  logic              w_accept;
  logic              w_load_rd;
  logic              w_we;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_op_acc    = write ? WR : RD;
    case (r_state)
      IDLE: begin
        if (write || read) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = c_cnt_init;
          w_state_nxt = (LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // With LATENCY=1 the edge entering DONE is also the acceptance edge, so the
  // read path must look at the live request rather than the latched one.
  always_comb begin
    w_rd_addr = (r_state == IDLE) ? mar_q : r_addr;
    w_rd_op   = (r_state == IDLE) ? w_op_acc : r_op;
    w_load_rd = (w_state_nxt == DONE) && (w_rd_op == RD);
  end

`ifdef MEM_RANGE_CHECK_EN
  assign w_addr_err = (32'(w_rd_addr) >= 32'(MEM_WORDS));
  assign mem_err    = (r_state == DONE) && r_err;
`else
  assign w_addr_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_op      <= RD;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
      r_mdatain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr <= mar_q;
        r_op   <= w_op_acc;
        r_err  <= w_addr_err;
        if (write) begin
          r_wdata <= mdr_q;
        end
      end
      if (w_load_rd) begin
        r_mdatain <= w_addr_err ? '0 : w_rdata;
      end
    end
  end

  // RAM commit happens on the edge leaving DONE.
  assign w_we = (r_state == DONE) && (r_op == WR) && !r_err;

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_addr),
    .wdata (r_wdata),
    .raddr (w_rd_addr),
    .rdata (w_rdata)
  );

  assign mdatain  = r_mdatain;
  assign mem_done = (r_state == DONE);
  assign mem_busy = (r_state != IDLE);

endmodule : mem_read_port
`default_nettype wire

// File: tb/tb_mem_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_read_port
//  Description : Directed self-checking bench for mem_read_port (LATENCY=2).
//                With MEM_RANGE_CHECK_EN defined, MEM_WORDS=256 and the
//                out-of-range read case is included.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_read_port;

  localparam int c_data_w  = 32;
  localparam int c_addr_w  = 9;
  localparam int c_latency = 2;

  logic                clk;
  logic                clr;
  logic [c_addr_w-1:0] mar_q;
  logic [c_data_w-1:0] mdr_q;
  logic                read;
  logic                write;
  logic [c_data_w-1:0] mdatain;
  logic                mem_done;
  logic                mem_busy;
  logic                mem_err_obs;

  int n_checks;
  int n_fail;

`ifdef MEM_RANGE_CHECK_EN
  logic mem_err;
  assign mem_err_obs = mem_err;
`else
  assign mem_err_obs = 1'b0;
`endif

  mem_read_port #(
    .DATA_W    (c_data_w),
    .ADDR_W    (c_addr_w),
    .LATENCY   (c_latency)
`ifdef MEM_RANGE_CHECK_EN
    ,
    .MEM_WORDS (256)
`endif
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .mar_q    (mar_q),
    .mdr_q    (mdr_q),
    .read     (read),
    .write    (write),
    .mdatain  (mdatain),
    .mem_done (mem_done),
`ifdef MEM_RANGE_CHECK_EN
    .mem_err  (mem_err),
`endif
    .mem_busy (mem_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1. Presents a request for one cycle, then switches
  // mar_q/mdr_q to addr_after / ~data to prove they were latched. Returns at
  // the IDLE cycle after completion with values captured during DONE.
  task automatic access(input string tag, input logic wr, input logic rd,
                        input logic [c_addr_w-1:0] addr, input logic [c_data_w-1:0] data,
                        input logic [c_addr_w-1:0] addr_after,
                        output logic [c_data_w-1:0] rdata, output logic err);
    int lat;
    write = wr;
    read  = rd;
    mar_q = addr;
    mdr_q = data;
    @(posedge clk); #1;
    write = 1'b0;
    read  = 1'b0;
    mar_q = addr_after;
    mdr_q = ~data;
    check({tag, "_busy"}, 32'(mem_busy), 32'd1);
    lat = 0;
    while (!mem_done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    // Accept edge N, DONE is entered on edge N+LATENCY-1.
    check({tag, "_lat"}, 32'(lat), 32'(c_latency - 1));
    rdata = mdatain;
    err   = mem_err_obs;
    @(posedge clk); #1;
    check({tag, "_idle"}, {30'd0, mem_busy, mem_done}, 32'd0);
  endtask

  logic [c_data_w-1:0] v_data;
  logic                v_err;
  int                  v_done_cnt;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr      = 1'b1;
    read     = 1'b0;
    write    = 1'b0;
    mar_q    = '0;
    mdr_q    = '0;

    // Asynchronous reset takes effect before any clock edge.
    #2;
    check("rst_mdatain", mdatain, 32'd0);
    check("rst_done_busy", {30'd0, mem_busy, mem_done}, 32'd0);
    #20 clr = 1'b0;
    @(posedge clk); #1;

    // Write 5 <- 3, then read it back.
    access("wr5", 1'b1, 1'b0, 9'd5, 32'h0000_0003, 9'd0, v_data, v_err);
    check("wr5_mdatain", v_data, 32'd0);
    access("rd5", 1'b0, 1'b1, 9'd5, 32'h0, 9'd0, v_data, v_err);
    check("rd5_data", v_data, 32'h3);
    check("rd5_err", 32'(v_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rd5_hold", mdatain, 32'h3);

    // Preload 8 and 9 with known values.
    access("wr8", 1'b1, 1'b0, 9'd8, 32'h0000_0088, 9'd0, v_data, v_err);
    access("wr9", 1'b1, 1'b0, 9'd9, 32'h0000_0055, 9'd0, v_data, v_err);

    // Write wins over read; mar_q moves to 8 after acceptance.
    access("prio", 1'b1, 1'b1, 9'd7, 32'h0000_0002, 9'd8, v_data, v_err);
    check("prio_mdatain", v_data, 32'h3);
    access("rd7", 1'b0, 1'b1, 9'd7, 32'h0, 9'd0, v_data, v_err);
    check("rd7_data", v_data, 32'h2);
    access("rd8", 1'b0, 1'b1, 9'd8, 32'h0, 9'd0, v_data, v_err);
    check("rd8_data", v_data, 32'h88);

    // Abort a write to 9 with a mid-cycle clr during WAIT.
    write = 1'b1;
    mar_q = 9'd9;
    mdr_q = 32'h0000_00AA;
    @(posedge clk); #1;
    write = 1'b0;
    check("abort_inwait", 32'(mem_busy), 32'd1);
    #2 clr = 1'b1;
    #1;
    check("abort_mdatain", mdatain, 32'd0);
    check("abort_done_busy", {30'd0, mem_busy, mem_done}, 32'd0);
    #2 clr = 1'b0;
    v_done_cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (mem_done) v_done_cnt++;
    end
    check("abort_nodone", 32'(v_done_cnt), 32'd0);
    access("rd9", 1'b0, 1'b1, 9'd9, 32'h0, 9'd0, v_data, v_err);
    check("rd9_data", v_data, 32'h55);

    // Back-to-back reads: sample k after the first edge is WAIT/DONE/IDLE
    // for k mod 3 = 1/2/0.
    read  = 1'b1;
    mar_q = 9'd5;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_done_%0d", k), 32'(mem_done), (k % 3 == 2) ? 32'd1 : 32'd0);
      check($sformatf("b2b_busy_%0d", k), 32'(mem_busy), (k % 3 == 0) ? 32'd0 : 32'd1);
    end
    read = 1'b0;
    check("b2b_data", mdatain, 32'h3);

`ifdef MEM_RANGE_CHECK_EN
    // Out-of-range read (300 >= 256): normal timing, zero data, error flag.
    access("oor", 1'b0, 1'b1, 9'd300, 32'h0, 9'd0, v_data, v_err);
    check("oor_data", v_data, 32'd0);
    check("oor_err", 32'(v_err), 32'd1);
    @(posedge clk); #1;
    check("oor_err_clear", 32'(mem_err_obs), 32'd0);
`endif

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_mem_read_port
`default_nettype wire
